// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the ALU opcode encodings, the default datapath width and the arbiter FSM state type.
// Opcodes are only named here for the requesters and the ALU; the arbiter passes them through
// without decoding.
package alu_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SR   = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  // One-hot FSM encoding.
  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StIssue = 3'b010,
    StResp  = 3'b100
  } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter.
// Request channel (per requester, packed, requester i at [i*WIDTH +: WIDTH] / [i*3 +: 3]):
//   req_valid, req_ready, req_operand1, req_operand2, req_opcode, req_is_signed
// Response channel:
//   resp_valid (one-hot or zero), resp_ready (per requester), resp_data (shared)
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = ALU_W
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_operand1;
  logic [NUM_REQ*WIDTH-1:0] req_operand2;
  logic [NUM_REQ*3-1:0]     req_opcode;
  logic [NUM_REQ-1:0]       req_is_signed;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [WIDTH-1:0]         resp_data;

  modport master (
    output req_valid, req_operand1, req_operand2, req_opcode, req_is_signed, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_operand1, req_operand2, req_opcode, req_is_signed, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational one-hot grant selection.
// Ports: req (request vector), ptr (search start index), en (grant enable), gnt (one-hot or zero).
// Macro ALU_ARB_RR_EN: defined -> round-robin search starting at ptr, wrapping past N-1 to 0;
// undefined -> fixed priority, lowest index wins and ptr is ignored.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt
);

`ifdef ALU_ARB_RR_EN
  // Walk offsets from farthest to nearest so the nearest requester to ptr overwrites the rest.
  always_comb begin
    gnt = '0;
    if (en) begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        if (req[(int'(ptr) + k) % int'(N)]) begin
          gnt = '0;
          gnt[(int'(ptr) + k) % int'(N)] = 1'b1;
        end
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = '0;
    if (en) begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        if (req[k]) begin
          gnt    = '0;
          gnt[k] = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between NUM_REQ requesters.
// Ports: clk, rst (async, active-high), bus (alu_arbiter_if.slave: request/response handshakes),
//   alu_operand1/alu_operand2/alu_opcode/alu_is_signed (registered drive of the ALU),
//   alu_res (ALU result, captured during the issue cycle).
// Flow: IDLE grants and latches one request, ISSUE drives the ALU and captures alu_res,
// RESP holds resp_valid for the granted requester until its resp_ready.
// Macro ALU_ARB_RR_EN: defined -> round-robin with a pointer register; undefined -> fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  output logic [2:0]       alu_opcode,
  output logic             alu_is_signed,
  input  logic [WIDTH-1:0] alu_res
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);

  alu_arb_state_t     state_q, state_d;
  logic [NUM_REQ-1:0] gnt;
  logic [PtrW-1:0]    gnt_idx, grant_q, ptr;
  logic               arb_en, accept, resp_hs;
  logic [WIDTH-1:0]   sel_op1, sel_op2, op1_q, op2_q, resp_data_q;
  logic [2:0]         sel_opc, opc_q;
  logic               sel_sgn, sgn_q;

  // Masking with rst keeps req_ready low while reset is held.
  assign arb_en = (state_q == StIdle) && !rst;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req (bus.req_valid),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (gnt)
  );

  // Payload mux driven by the one-hot grant.
  always_comb begin
    gnt_idx = '0;
    sel_op1 = '0;
    sel_op2 = '0;
    sel_opc = '0;
    sel_sgn = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        gnt_idx = PtrW'(i);
        sel_op1 = bus.req_operand1[i*WIDTH +: WIDTH];
        sel_op2 = bus.req_operand2[i*WIDTH +: WIDTH];
        sel_opc = bus.req_opcode[i*3 +: 3];
        sel_sgn = bus.req_is_signed[i];
      end
    end
  end

  assign accept  = |gnt;
  assign resp_hs = (state_q == StResp) && bus.resp_ready[grant_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  if (resp_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      opc_q       <= '0;
      sgn_q       <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        grant_q <= gnt_idx;
        op1_q   <= sel_op1;
        op2_q   <= sel_op2;
        opc_q   <= sel_opc;
        sgn_q   <= sel_sgn;
      end
      if (state_q == StIssue) begin
        resp_data_q <= alu_res;
      end
    end
  end

`ifdef ALU_ARB_RR_EN
  logic [PtrW-1:0] ptr_q;

  // Pointer advances only on a completed response, to the requester after the one served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (resp_hs) begin
      ptr_q <= (grant_q == PtrW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign bus.req_ready = gnt;
  assign bus.resp_data = resp_data_q;

  always_comb begin
    bus.resp_valid = '0;
    if (state_q == StResp) begin
      bus.resp_valid[grant_q] = 1'b1;
    end
  end

  assign alu_operand1  = op1_q;
  assign alu_operand2  = op2_q;
  assign alu_opcode    = opc_q;
  assign alu_is_signed = sgn_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational `ALU` instance between `NUM_REQ` requesters, such as the decode/execute stage and an address-generation unit. It accepts one operation at a time over a valid/ready handshake, drives the ALU from registered operands, captures `alu_res` into a result register and returns it to the granted requester over a second valid/ready handshake. It sits between the requesters and the ALU, and owns every ALU input.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `WIDTH`, default 32: operand and result width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input NUM_REQ: per-requester operation request.
- `req_ready` output NUM_REQ: per-requester accept; at most one bit high.
- `req_operand1` input NUM_REQ*WIDTH: packed first operands; requester i at [i*WIDTH +: WIDTH].
- `req_operand2` input NUM_REQ*WIDTH: packed second operands.
- `req_opcode` input NUM_REQ*3: packed 3-bit ALU opcodes.
- `req_is_signed` input NUM_REQ: per-requester signed flag.
- `resp_valid` output NUM_REQ: result available for requester i; one-hot or zero.
- `resp_ready` input NUM_REQ: requester i takes its result.
- `resp_data` output WIDTH: result, shared by all requesters and qualified by `resp_valid`.
- `alu_operand1`, `alu_operand2` output WIDTH: to the ALU.
- `alu_opcode` output 3: to the ALU.
- `alu_is_signed` output 1: to the ALU.
- `alu_res` input WIDTH: from the ALU.

## Operation
- FSM has three states: IDLE, ISSUE and RESP. It is one-hot encoded, and IDLE is the reset state.
- **IDLE:**
  - If any `req_valid` is high, the arbiter picks the winner g.
  - `req_ready[g]` is asserted combinationally in the same cycle.
  - On that edge, operand1/2, opcode and is_signed of g are latched, g is stored, and the FSM moves to ISSUE.
- **ISSUE:**
  - The latched fields drive the `alu_*` outputs.
  - `alu_res` is registered into `resp_data` at the edge, and the FSM moves to RESP.
- **RESP:**
  - `resp_valid[g]` is high and `resp_data` is held stable.
  - On `resp_ready[g]` the FSM returns to IDLE and the priority pointer updates.
  - `resp_ready` bits of other requesters are ignored.
- `req_ready` is 0 in ISSUE and RESP.
- Requester obligations:
  - Once `req_valid[i]` is high, requester i holds it and its payload stable until `req_ready[i]`.
  - Dropping a request early is a protocol violation, and the bench flags it.
- `alu_*` outputs keep their last latched values outside ISSUE; there is no toggling in IDLE.
- The block does no arithmetic. Opcode and is_signed pass through unmodified; opcode is not decoded.
- **Boundary behaviour:**
  - Simultaneous requests: exactly one is granted; the others wait with valid held.
  - `resp_ready[g]` low indefinitely: stays in RESP, and all other requesters stall.
  - A request arriving in the same cycle as the `resp_ready` handshake is seen in the next cycle (IDLE).
  - `rst` asserted in any state: the in-flight op is discarded and no response is issued.
  - Pointer wrap: the pointer wraps from NUM_REQ-1 to 0.

## Timing
- Accept at edge N; `resp_valid` is high in cycle N+2, so latency is 2 cycles.
- Back-to-back throughput: one op per 3 cycles when `resp_ready` is already high.
- Reset values:
  - `req_ready` = 0, `resp_valid` = 0, `resp_data` = 0.
  - `alu_operand1/2` = 0, `alu_opcode` = 3'b000, `alu_is_signed` = 0.
  - Stored grant = 0, priority pointer = 0, state = IDLE.
- Combinational paths:
  - `req_valid` -> `req_ready` only.
  - `resp_data` and `alu_*` are register outputs.

## Configuration
- Macro: `ALU_ARB_RR_EN`.
- **Defined:**
  - Round-robin arbitration.
  - After a completed response from g, the pointer moves to g+1 mod NUM_REQ.
  - The search for the next grant starts at the pointer.
- **Undefined:**
  - Fixed priority: the lowest index wins.
  - The pointer register is not built.

## Structure
- `alu_pkg` holds:
  - Opcode constants: OP_ADD=000, OP_SLL=001, OP_SLT=010, OP_SLTU=011, OP_XOR=100, OP_SR=101, OP_OR=110, OP_AND=111.
  - The FSM state enum `alu_arb_state_t`.
  - `ALU_W`=32.
- Sub-module `rr_arbiter` (parameter `N`):
  - Inputs `req[N]`, `ptr`, `en`; output one-hot `gnt[N]`.
  - Purely combinational; it contains the macro-selected priority logic.
- `alu_arbiter` owns the FSM, operand/result registers and the pointer. The ALU itself is instantiated outside, by the parent.

## Test plan
- **Single ADD:** req0 ADD 5 + 7, `resp_ready` high -> `req_ready[0]` in the accept cycle, `resp_valid[0]` 2 cycles later with `resp_data`=12, back in IDLE the next cycle.
- **Round-robin order:** after reset, req0 and req1 both valid continuously with distinct ops (XOR 0xF0F0 ^ 0x0FF0; OR 1 | 2) -> grants in the order 0,1,0,1. Correct results are 0xFF00 and 3.
- **Response stall:** hold `resp_ready[0]` low 4 cycles with req1 valid -> `resp_valid[0]` and `resp_data` stable, `req_ready[1]` stays 0, req1 accepted the cycle after the handshake.
- **Reset mid-operation:** assert `rst` during ISSUE of req1 SLTU 0xFFFFFFFF, 1 -> all outputs at reset values immediately, no `resp_valid`, the pointer back to 0.
- **Fixed priority:** `ALU_ARB_RR_EN` undefined, req0 and req1 always valid -> req0 granted every time, req1 never.
- **Pass-through:** req1 opcode 101 with is_signed=1 -> in ISSUE, `alu_opcode`=101 and `alu_is_signed`=1; `resp_data` equals the ALU model output for 0x80000000 >> 4.
